// File: rtl/quad_pkg.sv
// Shared types and Gray-code step decoding for the quadrature decoder.
package quad_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    localparam int STEP_FWD = 1;
    localparam int STEP_REV = -1;

    typedef struct packed {
        logic signed [1:0] step;
        logic              illegal;
    } step_t;

    // Position along the forward cycle: S00=0, S01=1, S11=2, S10=3.
    function automatic logic [1:0] pos_of(input quad_state_t s);
        logic [1:0] v;
        v = s;
        return {v[1], v[1] ^ v[0]};
    endfunction

    function automatic step_t step_of(input quad_state_t prev, input quad_state_t next);
        step_t      r;
        logic [1:0] d;
        d         = pos_of(next) - pos_of(prev);
        r.step    = '0;
        r.illegal = 1'b0;
        case (d)
            2'd1:    r.step = 2'(STEP_FWD);
            2'd3:    r.step = 2'(STEP_REV);
            2'd2:    r.illegal = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter for one raw pin.
module debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] != stable_o) begin
                // The DEB_CYCLES-th consecutive differing cycle commits the new value.
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    stable_o <= sync_q[1];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: debounced A/B, step decoding, detent division.
// Define QUAD_ERR_COUNT_EN to add the saturating illegal-transition counter err_count_o.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DETENT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_i,
    input  logic       b_i,
    output logic       enable_o,
    output logic       dir_o,
    output logic       error_o
`ifdef QUAD_ERR_COUNT_EN
    ,
    output logic [7:0] err_count_o
`endif
);

    localparam int unsigned AW = $clog2(DETENT_DIV) + 2;
    localparam logic signed [AW-1:0] ACC_POS = $signed(AW'(DETENT_DIV));
    localparam logic signed [AW-1:0] ACC_NEG = -$signed(AW'(DETENT_DIV));

    logic                 stable_a;
    logic                 stable_b;
    quad_state_t          stable_ab;
    quad_state_t          state_q;
    logic                 primed_q;
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_sum;
    step_t                st;

    debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_a (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (a_i),
        .stable_o(stable_a)
    );

    debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_b (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (b_i),
        .stable_o(stable_b)
    );

    assign stable_ab = quad_state_t'({stable_a, stable_b});

    always_comb begin
        st      = step_of(state_q, stable_ab);
        acc_sum = acc_q + AW'(st.step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S00;
            primed_q    <= 1'b0;
            acc_q       <= '0;
            enable_o    <= 1'b0;
            dir_o       <= 1'b0;
            error_o     <= 1'b0;
`ifdef QUAD_ERR_COUNT_EN
            err_count_o <= '0;
`endif
        end else begin
            enable_o <= 1'b0;
            error_o  <= 1'b0;
            if (stable_ab != state_q) begin
                state_q <= stable_ab;
                // First change after reset only aligns state with the resting position.
                if (!primed_q) begin
                    primed_q <= 1'b1;
                end else if (st.illegal) begin
                    error_o <= 1'b1;
`ifdef QUAD_ERR_COUNT_EN
                    if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
`endif
                end else if (acc_sum == ACC_POS) begin
                    enable_o <= 1'b1;
                    dir_o    <= 1'b1;
                    acc_q    <= '0;
                end else if (acc_sum == ACC_NEG) begin
                    enable_o <= 1'b1;
                    dir_o    <= 1'b0;
                    acc_q    <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with DEB_CYCLES=4, DETENT_DIV=4.
module tb_quad_decoder;

    localparam int DEB = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    logic a_i;
    logic b_i;
    logic enable_o;
    logic dir_o;
    logic error_o;
`ifdef QUAD_ERR_COUNT_EN
    logic [7:0] err_count_o;
`endif

    always #5 clk = ~clk;

    quad_decoder #(
        .DEB_CYCLES(DEB),
        .DETENT_DIV(DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_i        (a_i),
        .b_i        (b_i),
        .enable_o   (enable_o),
        .dir_o      (dir_o),
        .error_o    (error_o)
`ifdef QUAD_ERR_COUNT_EN
        ,
        .err_count_o(err_count_o)
`endif
    );

    typedef struct {
        logic [1:0] ab;
        int         en;
        int         err;
        int         dir;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int en_cnt;
    int err_cnt;
    int overlap = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive {a,b} and count output pulses over the following cycles.
    task automatic hold(input logic [1:0] ab, input int cycles);
        {a_i, b_i} = ab;
        en_cnt  = 0;
        err_cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (enable_o === 1'b1) en_cnt++;
            if (error_o === 1'b1) err_cnt++;
            if (enable_o === 1'b1 && error_o === 1'b1) overlap++;
        end
    endtask

    vec_t vecs[19];
    int   lat;
    int   tot_en;
    int   tot_err;

    initial begin
        vecs[0]  = '{2'b11, 0, 0, 0};  // priming: silent resync
        vecs[1]  = '{2'b00, 0, 1, 0};  // illegal jump resyncs to 00
        vecs[2]  = '{2'b01, 0, 0, 0};
        vecs[3]  = '{2'b11, 0, 0, 0};
        vecs[4]  = '{2'b10, 0, 0, 0};
        vecs[5]  = '{2'b00, 1, 0, 1};
        vecs[6]  = '{2'b10, 0, 0, 1};
        vecs[7]  = '{2'b11, 0, 0, 1};
        vecs[8]  = '{2'b01, 0, 0, 1};
        vecs[9]  = '{2'b00, 1, 0, 0};
        vecs[10] = '{2'b00, 0, 0, 0};
        vecs[11] = '{2'b01, 0, 0, 0};
        vecs[12] = '{2'b11, 0, 0, 0};
        vecs[13] = '{2'b01, 0, 0, 0};
        vecs[14] = '{2'b00, 0, 0, 0};
        vecs[15] = '{2'b01, 0, 0, 0};
        vecs[16] = '{2'b11, 0, 0, 0};
        vecs[17] = '{2'b10, 0, 0, 0};
        vecs[18] = '{2'b00, 1, 0, 1};

        rst = 1'b1;
        a_i = 1'b1;
        b_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset enable", int'(enable_o), 0);
        check("reset dir", int'(dir_o), 0);
        check("reset error", int'(error_o), 0);
`ifdef QUAD_ERR_COUNT_EN
        check("reset err_count", int'(err_count_o), 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            hold(vecs[i].ab, 10);
            check($sformatf("vec%0d enable", i), en_cnt, vecs[i].en);
            check($sformatf("vec%0d error", i), err_cnt, vecs[i].err);
            check($sformatf("vec%0d dir", i), int'(dir_o), vecs[i].dir);
        end
`ifdef QUAD_ERR_COUNT_EN
        check("err_count after table", int'(err_count_o), 1);
`endif

        // Latency: detent-completing change to enable_o is DEB+3 cycles.
        hold(2'b01, 10);
        hold(2'b11, 10);
        hold(2'b10, 10);
        check("pre-latency enable", en_cnt, 0);
        {a_i, b_i} = 2'b00;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (enable_o === 1'b1 && lat == 0) lat = i;
        end
        check("enable latency", lat, DEB + 3);
        check("latency dir", int'(dir_o), 1);

        // Glitch of DEB-1 cycles on a_i must not be seen.
        a_i = 1'b1;
        tot_en  = 0;
        tot_err = 0;
        repeat (DEB - 1) begin
            @(posedge clk);
            #1;
            if (enable_o === 1'b1) tot_en++;
            if (error_o === 1'b1) tot_err++;
        end
        hold(2'b00, 12);
        check("glitch enable", tot_en + en_cnt, 0);
        check("glitch error", tot_err + err_cnt, 0);
        hold(2'b01, 10);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b00, 10);
        check("post-glitch detent", en_cnt, 1);

        // Reset after 3 forward steps discards the partial detent.
        hold(2'b01, 10);
        hold(2'b11, 10);
        hold(2'b10, 10);
        rst = 1'b1;
        hold(2'b10, 3);
        check("mid-reset enable", en_cnt, 0);
        check("mid-reset dir", int'(dir_o), 0);
        check("mid-reset error", int'(error_o), 0);
`ifdef QUAD_ERR_COUNT_EN
        check("mid-reset err_count", int'(err_count_o), 0);
`endif
        rst = 1'b0;
        hold(2'b10, 10);
        check("re-prime enable", en_cnt, 0);
        check("re-prime error", err_cnt, 0);
        hold(2'b00, 10);
        check("post-reset step enable", en_cnt, 0);
        check("post-reset step error", err_cnt, 0);

        // 300 illegal jumps between 00 and 11.
        tot_en  = 0;
        tot_err = 0;
        for (int i = 0; i < 300; i++) begin
            hold((i % 2 == 0) ? 2'b11 : 2'b00, 10);
            tot_en  += en_cnt;
            tot_err += err_cnt;
        end
        check("jump errors", tot_err, 300);
        check("jump enables", tot_en, 0);
`ifdef QUAD_ERR_COUNT_EN
        check("err_count saturated", int'(err_count_o), 255);
`endif
        check("enable/error overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Rotary/quadrature encoder front end for the counter board.
- Turns raw, asynchronous A/B encoder pins into the single-cycle step pulse (enable) and direction level that drive the up/down counter's enable_i/dir_i inputs.
- Provides synchronisation, debouncing, Gray-code step decoding and detent division.

Parameters:
- DEB_CYCLES, 16: consecutive cycles a synchronised input must differ from its stable value before the new value is accepted; legal range 1..65535.
- DETENT_DIV, 4: quadrature steps per output pulse; legal values 1, 2, 4.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- a_i  input  1  encoder channel A, asynchronous raw pin
- b_i  input  1  encoder channel B, asynchronous raw pin
- enable_o  output  1  one-cycle pulse, one per DETENT_DIV net steps
- dir_o  output  1  1 = forward (CW), 0 = reverse; valid with enable_o, holds last value otherwise
- error_o  output  1  one-cycle pulse on an illegal (double-bit) transition

Behaviour:
- Reset: one clock domain (clk); reset synchronous, active-high on rst.
- Reset values:
  - all outputs 0
  - synchroniser flops 0
  - stable A/B = 00
  - accumulator 0
  - primed = 0
- Synchroniser: 2 flops per channel.
- Debounce, per channel independently:
  - counter increments while synced value != stable value
  - counter clears when synced value == stable value
  - when counter reaches DEB_CYCLES, the stable value takes the synced value and the counter clears
  - a glitch shorter than DEB_CYCLES is never seen
- Latency: raw change held from edge N updates stable at edge N+2+DEB_CYCLES; the resulting enable_o/error_o is asserted on edge N+3+DEB_CYCLES.
- Step FSM states, encoded as stable {A,B}: S00, S01, S11, S10.
  - forward = S00->S01->S11->S10->S00: step +1
  - reverse = reverse order: step -1
  - no change: no step
  - both bits change in the same cycle (S00<->S11, S01<->S10): illegal; error_o pulses, state resyncs to the new value, no step
- Priming: the first stable change after reset (primed = 0) resyncs silently, with no step and no error, then sets primed = 1. This prevents a false step when the encoder rests off 00.
- Accumulator: signed, width $clog2(DETENT_DIV)+2.
  - on a step, acc += step
  - if acc reaches +DETENT_DIV: enable_o = 1, dir_o = 1, acc = 0
  - if acc reaches -DETENT_DIV: enable_o = 1, dir_o = 0, acc = 0
  - a reversal mid-detent simply moves acc back; no pulse
- Rate and overlap:
  - at most one step per cycle, so at most one enable_o pulse per cycle
  - enable_o and error_o are never high together
- Reset mid-operation: rst overrides everything that cycle; any partial detent is discarded and priming is repeated.

Optional Feature:
- QUAD_ERR_COUNT_EN defined:
  - adds output port err_count_o, 8 bits
  - saturating count of illegal transitions; holds at 255
  - cleared by rst
- QUAD_ERR_COUNT_EN undefined: port and counter are absent; error_o is unchanged.

Decomposition:
- Package quad_pkg:
  - typedef enum logic [1:0] quad_state_t {S00, S01, S11, S10}
  - localparams STEP_FWD = +1, STEP_REV = -1
  - function step_of(prev, next) returning step and illegal flag
- Sub-module debounce, instantiated once per channel.
  - Parameter: DEB_CYCLES.
  - Ports: clk, rst, raw_i, stable_o.
  - Contains the synchroniser and the debounce counter.

Test Plan:
- Reset with a_i=b_i=1 held, DEB_CYCLES=4 -> stable becomes 11 at cycle 6; no enable_o, no error_o (priming); primed=1.
- From primed 00: drive the forward sequence 01,11,10,00, each held 10 cycles, DETENT_DIV=4 -> exactly one enable_o pulse, dir_o=1, asserted 7 cycles after the 00 edge.
- Reverse sequence 10,11,01,00 from 00 -> one enable_o pulse with dir_o=0; dir_o stays 0 afterwards.
- Forward 2 steps, then reverse 2 steps -> acc returns to 0, no enable_o; then 4 forward steps -> one pulse.
- Glitch on a_i of DEB_CYCLES-1 cycles -> stable unchanged, no output activity. Jump 00->11 held 10 cycles -> one error_o pulse, no enable_o; with QUAD_ERR_COUNT_EN, err_count_o=1; 300 such jumps -> err_count_o=255.
- Assert rst after 3 forward steps -> outputs 0, acc 0; one further forward step after priming -> no enable_o.
